// File: rtl/crypto_mm_pkg.sv
// Shared definitions for the memory-mapped secure RAM block.
//   - state_e  : FSM states of secure_ram_mm (ZERO exists only when
//                SECURE_RAM_ZEROIZE_EN is defined)
//   - rsrc_e   : which source currently drives rdata
//   - RESP_OK / RESP_ERR : err encoding on a completion
//   - ctrl_offset() : byte offset of the CTRL register from BASE_ADDR
package crypto_mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1
`ifdef SECURE_RAM_ZEROIZE_EN
        ,
        ST_ZERO = 2'd2
`endif
    } state_e;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_CTRL = 2'd2
    } rsrc_e;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // CTRL occupies the first word past the end of the RAM window.
    function automatic logic [32:0] ctrl_offset(input int unsigned ram_words);
        return 33'(ram_words) << 2;
    endfunction

endpackage

// File: rtl/secure_ram_mm_bank.sv
// Storage bank for secure_ram_mm: one write port with byte enables and a
// registered read port; written so synthesis infers block RAM.
// Ports:
//   clk          - clock
//   we/waddr/wdata/wstrb - write port, bytes with wstrb=1 are written
//   re/raddr     - read enable/address; rdata updates only when re=1
//   rdata        - registered read data (holds while re=0)
module secure_ram_mm_bank #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter int unsigned AW        = $clog2(RAM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [RAM_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/secure_ram_mm.sv
// Memory-mapped secure RAM: address decode, request FSM and optional
// zeroize engine around the secure_ram_mm_bank storage.
// Optional feature macro: SECURE_RAM_ZEROIZE_EN adds the CTRL register at
// BASE_ADDR + 4*RAM_WORDS, the zeroize counter and the ZERO state.
// Ports:
//   clk, rst (async, active-low)
//   addr, wdata, wstrb, we, valid - request, held stable until ready
//   rdata, ready, err             - one-cycle completion with error flag
module secure_ram_mm
    import crypto_mm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_4000,
    parameter int unsigned RAM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        we,
    input  logic        valid,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned AW      = $clog2(RAM_WORDS);
    localparam logic [32:0] WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_END = WIN_LO + ctrl_offset(RAM_WORDS);

    // Decode is done in 33 bits so a window ending at 4 GiB cannot wrap.
    logic [32:0]   addr_x;
    logic          in_ram;
    logic          in_ctrl;
    logic          sel;
    logic          aligned;
    logic [AW-1:0] idx;

    assign addr_x  = {1'b0, addr};
    assign in_ram  = (addr_x >= WIN_LO) && (addr_x < WIN_END);
`ifdef SECURE_RAM_ZEROIZE_EN
    assign in_ctrl = (addr_x == WIN_END);
`else
    assign in_ctrl = 1'b0;
`endif
    assign sel     = in_ram | in_ctrl;
    assign aligned = (addr[1:0] == 2'b00);
    assign idx     = AW'((addr - BASE_ADDR) >> 2);

    state_e state_q, state_d;
    rsrc_e  src_q, src_d;
    logic   ready_q, ready_d;
    logic   err_q, err_d;
`ifdef SECURE_RAM_ZEROIZE_EN
    localparam logic [AW-1:0] LAST_IDX = AW'(RAM_WORDS - 1);
    logic [AW-1:0] cnt_q, cnt_d;
    logic          zero_go_q, zero_go_d;
    logic          busy_q, busy_d;
`endif

    logic          bank_we;
    logic          bank_re;
    logic [AW-1:0] bank_waddr;
    logic [31:0]   bank_wdata;
    logic [3:0]    bank_wstrb;
    logic [31:0]   bank_rdata;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        ready_d    = 1'b0;
        err_d      = RESP_OK;
        bank_we    = 1'b0;
        bank_re    = 1'b0;
        bank_waddr = idx;
        bank_wdata = wdata;
        bank_wstrb = wstrb;
`ifdef SECURE_RAM_ZEROIZE_EN
        cnt_d      = cnt_q;
        zero_go_d  = zero_go_q;
        busy_d     = busy_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid && sel && !ready_q) begin
                    ready_d = 1'b1;
                    state_d = ST_RESP;
                    if (in_ram && !aligned) begin
                        err_d = RESP_ERR;
                        src_d = SRC_ZERO;
                    end else if (in_ram) begin
                        if (we) begin
                            bank_we = 1'b1;
                        end else begin
                            bank_re = 1'b1;
                            src_d   = SRC_RAM;
                        end
                    end
`ifdef SECURE_RAM_ZEROIZE_EN
                    else begin
                        if (we) begin
                            zero_go_d = wdata[0] & wstrb[0];
                        end else begin
                            src_d  = SRC_CTRL;
                            busy_d = 1'b0;
                        end
                    end
`endif
                end
            end
            ST_RESP: begin
`ifdef SECURE_RAM_ZEROIZE_EN
                // A start write finishes its normal completion before wiping.
                state_d   = zero_go_q ? ST_ZERO : ST_IDLE;
                zero_go_d = 1'b0;
                cnt_d     = '0;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef SECURE_RAM_ZEROIZE_EN
            ST_ZERO: begin
                bank_we    = 1'b1;
                bank_waddr = cnt_q;
                bank_wdata = 32'h0;
                bank_wstrb = 4'hF;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
                // Only CTRL is serviced while wiping; writes are ignored.
                if (valid && in_ctrl && !ready_q) begin
                    ready_d = 1'b1;
                    if (!we) begin
                        src_d  = SRC_CTRL;
                        busy_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            src_q     <= SRC_ZERO;
            ready_q   <= 1'b0;
            err_q     <= RESP_OK;
`ifdef SECURE_RAM_ZEROIZE_EN
            cnt_q     <= '0;
            zero_go_q <= 1'b0;
            busy_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
`ifdef SECURE_RAM_ZEROIZE_EN
            cnt_q     <= cnt_d;
            zero_go_q <= zero_go_d;
            busy_q    <= busy_d;
`endif
        end
    end

    secure_ram_mm_bank #(
        .RAM_WORDS(RAM_WORDS),
        .AW       (AW)
    ) u_bank (
        .clk  (clk),
        .we   (bank_we),
        .waddr(bank_waddr),
        .wdata(bank_wdata),
        .wstrb(bank_wstrb),
        .re   (bank_re),
        .raddr(idx),
        .rdata(bank_rdata)
    );

    // The bank read register only loads on accepted reads, so selecting it
    // here keeps rdata stable until the next completion.
    always_comb begin
        case (src_q)
            SRC_RAM:  rdata = bank_rdata;
`ifdef SECURE_RAM_ZEROIZE_EN
            SRC_CTRL: rdata = {31'b0, busy_q};
`endif
            default:  rdata = 32'h0;
        endcase
    end

    assign ready = ready_q;
    assign err   = err_q;

endmodule
